// File: rtl/ic_pkg.sv
// Shared definitions for the address router: default ROM/RAM/AXI-bridge
// windows, the ID-width helper and the default decode-error ID.
package ic_pkg;

   localparam logic [31:0] ROM_MATCH = 32'h1000_0000;
   localparam logic [31:0] ROM_MASK  = 32'hFFFF_C000;
   localparam logic [31:0] RAM_MATCH = 32'h2000_0000;
   localparam logic [31:0] RAM_MASK  = 32'hFFFF_0000;
   localparam logic [31:0] AXI_MATCH = 32'h4000_0000;
   localparam logic [31:0] AXI_MASK  = 32'hF000_0000;

   localparam int DEF_NREGIONS = 3;

   // Region i lives in bits [i*32 +: 32]; ROM is region 0.
   localparam logic [DEF_NREGIONS*32-1:0] DEF_MAP_MATCH = {AXI_MATCH, RAM_MATCH, ROM_MATCH};
   localparam logic [DEF_NREGIONS*32-1:0] DEF_MAP_MASK  = {AXI_MASK,  RAM_MASK,  ROM_MASK};

   // The ID space covers every device port plus one decode-error ID.
   function automatic int ic_idw(input int nregions);
      return $clog2(nregions + 1);
   endfunction

   // Decode-error ID for the default three-region map (always equals NREGIONS).
   localparam int DEF_ERR_ID = DEF_NREGIONS;

endpackage

// File: rtl/ic_id_fifo.sv
// Generic synchronous FIFO used to remember, in order, which port owes the
// master its next response. DEPTH must be a power of two so the pointers
// wrap naturally. Push is refused while full, even if a pop happens in the
// same cycle; pop is refused while empty.
module ic_id_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic                   g_clk,
   input  logic                   g_resetn,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       data_in,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge g_clk) begin
      if (do_push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/ic_addr_router.sv
// Address router: decodes the master request against NREGIONS mask/match
// windows, forwards the handshake to one device port, and steers responses
// back in request order using an ID FIFO. Unmapped requests are accepted and
// answered by the router itself with an error response.
// Optional feature macro: IC_ADDR_ROUTER_ERR_LOG_EN adds err_count/err_addr.
module ic_addr_router
   import ic_pkg::*;
#(
   parameter int                         NREGIONS        = DEF_NREGIONS,
   parameter int                         AW              = 32,
   parameter logic [NREGIONS*AW-1:0]     MAP_MATCH       = DEF_MAP_MATCH,
   parameter logic [NREGIONS*AW-1:0]     MAP_MASK        = DEF_MAP_MASK,
   parameter int                         MAX_OUTSTANDING = 4
) (
   input  logic                          g_clk,
   input  logic                          g_resetn,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [AW-1:0]                 req_addr,
   output logic [NREGIONS-1:0]           dev_req_valid,
   input  logic [NREGIONS-1:0]           dev_req_ready,
   input  logic [NREGIONS-1:0]           dev_rsp_valid,
   output logic [NREGIONS-1:0]           dev_rsp_ready,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic                          rsp_error,
   output logic [ic_idw(NREGIONS)-1:0]   rsp_sel
`ifdef IC_ADDR_ROUTER_ERR_LOG_EN
   ,
   output logic [15:0]                   err_count,
   output logic [AW-1:0]                 err_addr
`endif
);

   localparam int             IDW    = ic_idw(NREGIONS);
   localparam logic [IDW-1:0] ERR_ID = IDW'(NREGIONS);

   logic [IDW-1:0]                     sel;
   logic                               sel_dev_ready;
   logic [IDW-1:0]                     head;
   logic                               full;
   logic                               empty;
   logic [$clog2(MAX_OUTSTANDING):0]   count;
   logic                               unused_count;
   logic                               push;
   logic                               pop;

   // Lowest-index hit wins so overlapping windows resolve deterministically.
   always_comb begin
      sel = ERR_ID;
      for (int i = NREGIONS - 1; i >= 0; i--) begin
         if ((req_addr & MAP_MASK[i*AW +: AW]) == MAP_MATCH[i*AW +: AW]) sel = IDW'(i);
      end
   end

   // Forward the request to the selected device only when an ID slot is free.
   always_comb begin
      dev_req_valid = '0;
      sel_dev_ready = 1'b0;
      for (int i = 0; i < NREGIONS; i++) begin
         dev_req_valid[i] = req_valid && !full && (sel == IDW'(i));
         if (sel == IDW'(i)) sel_dev_ready = dev_req_ready[i];
      end
      req_ready = req_valid && !full && ((sel == ERR_ID) || sel_dev_ready);
   end

   // Only the port at the FIFO head may answer; an error head answers itself.
   always_comb begin
      dev_rsp_ready = '0;
      rsp_valid     = 1'b0;
      rsp_error     = 1'b0;
      rsp_sel       = '0;
      if (!empty) begin
         rsp_sel = head;
         if (head == ERR_ID) begin
            rsp_valid = 1'b1;
            rsp_error = 1'b1;
         end else begin
            for (int i = 0; i < NREGIONS; i++) begin
               if (head == IDW'(i)) begin
                  rsp_valid        = dev_rsp_valid[i];
                  dev_rsp_ready[i] = rsp_ready;
               end
            end
         end
      end
   end

   assign push         = req_valid && req_ready;
   assign pop          = rsp_valid && rsp_ready;
   assign unused_count = ^count;

   ic_id_fifo #(
      .WIDTH (IDW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .push     (push),
      .pop      (pop),
      .data_in  (sel),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

`ifdef IC_ADDR_ROUTER_ERR_LOG_EN
   // Log accepted decode errors: saturating count plus last offending address.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         err_count <= '0;
         err_addr  <= '0;
      end else if (push && (sel == ERR_ID)) begin
         if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         err_addr <= req_addr;
      end
   end
`endif

endmodule

// File: tb/tb_ic_addr_router.sv
// Self-checking bench for ic_addr_router with the default ROM/RAM/AXI map.
module tb_ic_addr_router;

   logic        g_clk = 1'b0;
   logic        g_resetn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  dev_req_valid;
   logic [2:0]  dev_req_ready;
   logic [2:0]  dev_rsp_valid;
   logic [2:0]  dev_rsp_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_error;
   logic [1:0]  rsp_sel;
`ifdef IC_ADDR_ROUTER_ERR_LOG_EN
   logic [15:0] err_count;
   logic [31:0] err_addr;
`endif

   int errors = 0;
   int checks = 0;

   always #5 g_clk = ~g_clk;

   ic_addr_router dut (
      .g_clk         (g_clk),
      .g_resetn      (g_resetn),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .dev_req_valid (dev_req_valid),
      .dev_req_ready (dev_req_ready),
      .dev_rsp_valid (dev_rsp_valid),
      .dev_rsp_ready (dev_rsp_ready),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_error     (rsp_error),
      .rsp_sel       (rsp_sel)
`ifdef IC_ADDR_ROUTER_ERR_LOG_EN
      ,
      .err_count     (err_count),
      .err_addr      (err_addr)
`endif
   );

   // Reference decode straight from the address map: 0=ROM, 1=RAM, 2=AXI, 3=error.
   function automatic int ref_decode(input logic [31:0] a);
      if (a >= 32'h1000_0000 && a <= 32'h1000_3FFF) return 0;
      if (a[31:16] == 16'h2000) return 1;
      if (a[31:28] == 4'h4) return 2;
      return 3;
   endfunction

   // Advance one clock; inputs are driven 1 time unit after the edge.
   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid     = 1'b0;
      req_addr      = '0;
      dev_req_ready = '0;
      dev_rsp_valid = '0;
      rsp_ready     = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      g_resetn = 1'b0;
      step();
      step();
      g_resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (req_ready !== 1'b0 || dev_req_valid !== 3'b000 || dev_rsp_ready !== 3'b000) begin
         errors++;
         $display("FAIL reset_req: req_ready=%b dev_req_valid=%b dev_rsp_ready=%b, want 0/000/000",
                  req_ready, dev_req_valid, dev_rsp_ready);
      end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_sel !== 2'd0) begin
         errors++;
         $display("FAIL reset_rsp: rsp_valid=%b rsp_error=%b rsp_sel=%0d, want 0/0/0",
                  rsp_valid, rsp_error, rsp_sel);
      end
`ifdef IC_ADDR_ROUTER_ERR_LOG_EN
      checks++;
      if (err_count !== 16'd0 || err_addr !== 32'd0) begin
         errors++;
         $display("FAIL reset_errlog: err_count=%0d err_addr=%h, want 0/0", err_count, err_addr);
      end
`endif
   endtask

   task automatic test_mapped();
      do_reset();
      req_valid = 1'b1; req_addr = 32'h2000_0010; dev_req_ready = 3'b010;
      #1;
      checks++;
      if (dev_req_valid !== 3'b010 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL mapped_req: dev_req_valid=%b req_ready=%b, want 010/1", dev_req_valid, req_ready);
      end
      step();
      req_valid = 1'b0; dev_req_ready = 3'b000; dev_rsp_valid = 3'b010; rsp_ready = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_sel !== 2'd1 || dev_rsp_ready !== 3'b010) begin
         errors++;
         $display("FAIL mapped_rsp: rsp_valid=%b rsp_error=%b rsp_sel=%0d dev_rsp_ready=%b, want 1/0/1/010",
                  rsp_valid, rsp_error, rsp_sel, dev_rsp_ready);
      end
      step();
      dev_rsp_valid = 3'b000;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || dev_rsp_ready !== 3'b000) begin
         errors++;
         $display("FAIL mapped_drain: rsp_valid=%b dev_rsp_ready=%b, want 0/000", rsp_valid, dev_rsp_ready);
      end
   endtask

   task automatic test_decode_error();
      do_reset();
      req_valid = 1'b1; req_addr = 32'h1000_4000;
      #1;
      checks++;
      if (req_ready !== 1'b1 || dev_req_valid !== 3'b000 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL err_req: req_ready=%b dev_req_valid=%b rsp_valid=%b, want 1/000/0",
                  req_ready, dev_req_valid, rsp_valid);
      end
      step();
      req_valid = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_sel !== 2'd3) begin
         errors++;
         $display("FAIL err_rsp: rsp_valid=%b rsp_error=%b rsp_sel=%0d, want 1/1/3",
                  rsp_valid, rsp_error, rsp_sel);
      end
`ifdef IC_ADDR_ROUTER_ERR_LOG_EN
      checks++;
      if (err_count !== 16'd1 || err_addr !== 32'h1000_4000) begin
         errors++;
         $display("FAIL err_log: err_count=%0d err_addr=%h, want 1/10004000", err_count, err_addr);
      end
`endif
      rsp_ready = 1'b1;
      step();
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
         errors++;
         $display("FAIL err_pop: rsp_valid=%b rsp_error=%b, want 0/0", rsp_valid, rsp_error);
      end
   endtask

   task automatic test_ordering();
      logic [31:0] addrs [3];
      int          want  [3];
      addrs[0] = 32'h2000_0000; addrs[1] = 32'h4000_1234; addrs[2] = 32'h1000_0100;
      want[0] = 1; want[1] = 2; want[2] = 0;
      do_reset();
      dev_req_ready = 3'b111;
      for (int k = 0; k < 3; k++) begin
         req_valid = 1'b1; req_addr = addrs[k];
         step();
      end
      req_valid = 1'b0; dev_req_ready = 3'b000;
      dev_rsp_valid = 3'b101; rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b0 || rsp_sel !== 2'd1 || dev_rsp_ready !== 3'b010) begin
            errors++;
            $display("FAIL order_hold: rsp_valid=%b rsp_sel=%0d dev_rsp_ready=%b, want 0/1/010",
                     rsp_valid, rsp_sel, dev_rsp_ready);
         end
         step();
      end
      dev_rsp_valid = 3'b111;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || int'(rsp_sel) != want[k]) begin
            errors++;
            $display("FAIL order_seq%0d: rsp_valid=%b rsp_sel=%0d, want 1/%0d", k, rsp_valid, rsp_sel, want[k]);
         end
         step();
      end
      dev_rsp_valid = 3'b000;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL order_done: rsp_valid=%b, want 0", rsp_valid);
      end
   endtask

   task automatic test_full();
      do_reset();
      dev_req_ready = 3'b111; req_valid = 1'b1; req_addr = 32'h2000_0040;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_fill%0d: req_ready=%b, want 1", k, req_ready);
         end
         step();
      end
      #1;
      checks++;
      if (req_ready !== 1'b0 || dev_req_valid !== 3'b000) begin
         errors++;
         $display("FAIL full_block: req_ready=%b dev_req_valid=%b, want 0/000", req_ready, dev_req_valid);
      end
      dev_rsp_valid = 3'b010; rsp_ready = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_pop_cycle: rsp_valid=%b req_ready=%b, want 1/0", rsp_valid, req_ready);
      end
      step();
      rsp_ready = 1'b0; dev_rsp_valid = 3'b000;
      #1;
      checks++;
      if (req_ready !== 1'b1 || dev_req_valid !== 3'b010) begin
         errors++;
         $display("FAIL full_after_pop: req_ready=%b dev_req_valid=%b, want 1/010", req_ready, dev_req_valid);
      end
      step();
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_refill: req_ready=%b, want 0", req_ready);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req_valid = 1'b1; req_addr = 32'h1000_0000; dev_req_ready = 3'b000; rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (req_ready !== 1'b0 || dev_req_valid !== 3'b001 || rsp_valid !== 1'b0 || rsp_sel !== 2'd0) begin
            errors++;
            $display("FAIL bp_hold%0d: req_ready=%b dev_req_valid=%b rsp_valid=%b rsp_sel=%0d, want 0/001/0/0",
                     k, req_ready, dev_req_valid, rsp_valid, rsp_sel);
         end
         step();
      end
      dev_req_ready = 3'b001;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: req_ready=%b, want 1", req_ready);
      end
      step();
      req_valid = 1'b0;
      #1;
      checks++;
      if (rsp_sel !== 2'd0 || dev_rsp_ready !== 3'b001 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_outstanding: rsp_sel=%0d dev_rsp_ready=%b rsp_valid=%b, want 0/001/0",
                  rsp_sel, dev_rsp_ready, rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] addrs [3];
      addrs[0] = 32'h2000_0000; addrs[1] = 32'h0000_0000; addrs[2] = 32'h4000_0000;
      do_reset();
      dev_req_ready = 3'b111;
      for (int k = 0; k < 3; k++) begin
         req_valid = 1'b1; req_addr = addrs[k];
         step();
      end
      req_valid = 1'b0;
      g_resetn = 1'b0;
      step();
      g_resetn = 1'b1;
      rsp_ready = 1'b1; dev_rsp_valid = 3'b111;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_sel !== 2'd0 || dev_rsp_ready !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid: rsp_valid=%b rsp_sel=%0d dev_rsp_ready=%b, want 0/0/000",
                  rsp_valid, rsp_sel, dev_rsp_ready);
      end
`ifdef IC_ADDR_ROUTER_ERR_LOG_EN
      checks++;
      if (err_count !== 16'd0) begin
         errors++;
         $display("FAIL rst_mid_errlog: err_count=%0d, want 0", err_count);
      end
`endif
   endtask

   // Random traffic against a queue-of-owners model of the router.
   task automatic test_random();
      int          q[$];
      int          d;
      int          head;
      int          kind;
      logic        exp_req_ready;
      logic [2:0]  exp_dev_req_valid;
      logic        exp_rsp_valid;
      logic        exp_rsp_error;
      logic [1:0]  exp_rsp_sel;
      logic [2:0]  exp_dev_rsp_ready;
      logic        full;
      int          exp_err_cnt;
      logic [31:0] exp_err_addr;
      do_reset();
      exp_err_cnt  = 0;
      exp_err_addr = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0:       req_addr = 32'h1000_0000 | ($urandom & 32'h0000_3FFF);
            1:       req_addr = 32'h2000_0000 | ($urandom & 32'h0000_FFFF);
            2:       req_addr = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
            3:       req_addr = 32'h1000_4000 + ($urandom & 32'h0000_00FF);
            default: req_addr = $urandom;
         endcase
         req_valid     = ($urandom_range(0, 3) != 0);
         dev_req_ready = 3'($urandom);
         dev_rsp_valid = 3'($urandom);
         rsp_ready     = ($urandom_range(0, 2) != 0);
         #1;
         d    = ref_decode(req_addr);
         full = (q.size() == 4);
         head = (q.size() != 0) ? q[0] : -1;
         exp_dev_req_valid = (req_valid && !full && d < 3) ? 3'(1 << d) : 3'b000;
         exp_req_ready     = req_valid && !full && ((d == 3) || dev_req_ready[d]);
         exp_rsp_valid     = (head == 3) ? 1'b1 : (head >= 0) ? dev_rsp_valid[head] : 1'b0;
         exp_rsp_error     = (head == 3);
         exp_rsp_sel       = (head >= 0) ? 2'(head) : 2'd0;
         exp_dev_rsp_ready = (head >= 0 && head < 3 && rsp_ready) ? 3'(1 << head) : 3'b000;
         checks++;
         if (req_ready !== exp_req_ready || dev_req_valid !== exp_dev_req_valid) begin
            errors++;
            $display("FAIL rand_req c%0d: req_ready=%b dev_req_valid=%b, want %b/%b",
                     cyc, req_ready, dev_req_valid, exp_req_ready, exp_dev_req_valid);
         end
         checks++;
         if (rsp_valid !== exp_rsp_valid || rsp_error !== exp_rsp_error ||
             rsp_sel !== exp_rsp_sel || dev_rsp_ready !== exp_dev_rsp_ready) begin
            errors++;
            $display("FAIL rand_rsp c%0d: valid=%b err=%b sel=%0d dev_rsp_ready=%b, want %b/%b/%0d/%b",
                     cyc, rsp_valid, rsp_error, rsp_sel, dev_rsp_ready,
                     exp_rsp_valid, exp_rsp_error, exp_rsp_sel, exp_dev_rsp_ready);
         end
`ifdef IC_ADDR_ROUTER_ERR_LOG_EN
         checks++;
         if (err_count !== 16'(exp_err_cnt) || err_addr !== exp_err_addr) begin
            errors++;
            $display("FAIL rand_errlog c%0d: err_count=%0d err_addr=%h, want %0d/%h",
                     cyc, err_count, err_addr, exp_err_cnt, exp_err_addr);
         end
`endif
         if (exp_rsp_valid && rsp_ready) void'(q.pop_front());
         if (exp_req_ready) begin
            q.push_back(d);
            if (d == 3) begin
               exp_err_cnt  = exp_err_cnt + 1;
               exp_err_addr = req_addr;
            end
         end
         step();
      end
   endtask

   initial begin
      g_resetn = 1'b0;
      idle_inputs();
      test_reset();
      test_mapped();
      test_decode_error();
      test_ordering();
      test_full();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ic_addr_router.md
Name: ic_addr_router

Overview:
- Parametrised successor to the fixed three-way interconnect decoder. Decodes request addresses against NREGIONS mask/match windows and forwards the request handshake to the selected device port.
- Tracks outstanding transactions in an in-order ID FIFO, so each device response is steered back to the single requester.
- Unmapped addresses are accepted. The router then generates its own error response, in order.
- Sits between a CPU or DMA master port and the ROM/RAM/AXI-bridge device ports.

Parameters:
- NREGIONS, 3, number of device ports / address windows (1..15).
- AW, 32, address width.
- MAP_MATCH, {32'h4000_0000,32'h2000_0000,32'h1000_0000}, packed NREGIONS*AW match values; region i in bits [i*AW +: AW].
- MAP_MASK, {32'hF000_0000,32'hFFFF_0000,32'hFFFF_C000}, packed NREGIONS*AW masks.
- MAX_OUTSTANDING, 4, ID FIFO depth (power of two, >=2).

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  synchronous active-low reset
- req_valid  in  1  master request valid
- req_ready  out  1  master request accepted this cycle
- req_addr  in  AW  request address
- dev_req_valid  out  NREGIONS  one-hot request valid per device
- dev_req_ready  in  NREGIONS  per-device request ready
- dev_rsp_valid  in  NREGIONS  per-device response valid
- dev_rsp_ready  out  NREGIONS  per-device response ready
- rsp_valid  out  1  response to master valid
- rsp_ready  in  1  master accepts response
- rsp_error  out  1  response is a decode error (valid with rsp_valid)
- rsp_sel  out  IDW  ID of responding port (NREGIONS = error) for external data muxing

Behaviour:
- Clock/reset: clock g_clk; reset g_resetn, synchronous, active-low.
- Reset: FIFO empty, count=0.
  - All outputs are combinational from state and inputs.
  - With req_valid=0 and an empty FIFO: req_ready=0, dev_req_valid=0, dev_rsp_ready=0, rsp_valid=0, rsp_error=0, rsp_sel=0.
- IDW: IDW = $clog2(NREGIONS+1). ID value NREGIONS denotes a decode error.
- Decode (combinational): hit[i] = ((req_addr & MASK[i]) == MATCH[i]).
  - sel = lowest i with hit[i] set; overlapping windows resolve to the lowest index.
  - If no hit, sel = NREGIONS (error).
- Forwarding: dev_req_valid[sel] = req_valid && !full && sel<NREGIONS. All other bits are 0.
- Request ready:
  - Mapped: req_ready = req_valid && !full && dev_req_ready[sel].
  - Error: req_ready = req_valid && !full.
- Push: on req_valid && req_ready, push sel into the ID FIFO.
- Full condition:
  - full = (count == MAX_OUTSTANDING).
  - No push while full, even if a pop occurs in the same cycle.
- Responses (head = FIFO head ID, valid when count != 0):
  - Head is a device: rsp_valid = dev_rsp_valid[head]; dev_rsp_ready[head] = rsp_ready && count!=0. All other dev_rsp_ready bits are 0.
  - Head is an error: rsp_valid=1 and rsp_error=1. Minimum latency is 1 cycle after acceptance.
  - rsp_sel = head whenever count != 0.
- Pop: on rsp_valid && rsp_ready.
- Simultaneous push and pop: count is unchanged; pointers both advance; pointers wrap modulo MAX_OUTSTANDING.
- Non-head responses: dev_rsp_valid from a non-head device is ignored (not acknowledged) until that device reaches the head.
- Handshake rules:
  - The master must hold req_addr stable while req_valid && !req_ready.
  - The router never deasserts dev_req_valid without acceptance unless req_valid drops.
- Reset mid-operation: all outstanding IDs are discarded. Devices must also be reset.

Optional Feature:
- Macro: IC_ADDR_ROUTER_ERR_LOG_EN.
- When defined, adds outputs err_count (16 bits) and err_addr (AW bits).
  - err_count is a saturating counter of accepted decode-error requests; it holds at 16'hFFFF.
  - err_addr captures req_addr of the most recent accepted error request.
  - Both reset to 0.
- When undefined, neither port nor register exists, and behaviour is otherwise identical.

Decomposition:
- Package ic_pkg holds:
  - default map constants (ROM/RAM/AXI match and mask);
  - the IDW computation function;
  - the error-ID constant.
- Natural sub-module: ic_id_fifo, a generic synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty/count/head outputs.
- The decode loop and response steering stay in ic_addr_router.

Test Plan:
- Mapped request: req_addr=32'h2000_0010, dev_req_ready[1]=1 → dev_req_valid=3'b010, req_ready=1.
  - Then dev_rsp_valid[1]=1, rsp_ready=1 → rsp_valid=1, rsp_error=0, rsp_sel=1, dev_rsp_ready=3'b010.
- Decode error: req_addr=32'h1000_4000, just outside ROM → req_ready=1, dev_req_valid=0.
  - Next cycle rsp_valid=1, rsp_error=1, rsp_sel=3.
  - With ERR_LOG_EN: err_count=1, err_addr=32'h1000_4000.
- Ordering: issue to RAM, then AXI, then ROM; assert AXI and ROM responses first → responses held until the RAM response.
  - Master sees rsp_sel sequence 1, 2, 0.
- Full: with rsp_ready=0, accept 4 requests → the 5th sees req_ready=0.
  - A cycle with a pop plus a pending request does not accept; acceptance occurs the following cycle.
- Backpressure: dev_req_ready[0]=0 with req_addr=32'h1000_0000 → req_ready=0, dev_req_valid=3'b001 held, FIFO count unchanged.
- Reset: assert g_resetn=0 with 3 outstanding → next cycle rsp_valid=0, count=0.
  - With ERR_LOG_EN: err_count=0.
